// File: rtl/output_tx.sv
// Output transmitter: an OUT strobe loads OUTR and sends it as one 8N1 serial
// frame (start bit, eight data bits LSB first, stop bit) on an idle-high line.
// FGO reports readiness for the next byte; strobes during a frame are dropped.
module output_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic [7:0] Data,
  input  logic       LD,
  output logic [7:0] Q,
  output logic       FGO,
  output logic       TX,
  output logic       BUSY
);

  // Baud counter spans 0..CLKS_PER_BIT-1; at least one bit wide.
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    outr_q, outr_d;
  logic          tx_q, tx_d;
  logic          fgo_q, fgo_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CNT_MAX);

  // State register: all frame state, cleared asynchronously to an idle line.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      outr_q  <= 8'h00;
      tx_q    <= 1'b1;
      fgo_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      outr_q  <= outr_d;
      tx_q    <= tx_d;
      fgo_q   <= fgo_d;
    end
  end

  // Next-state logic: accept LD only in IDLE, advance on each bit-period end.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    outr_d  = outr_q;
    case (state_q)
      IDLE: begin
        if (LD) begin
          outr_d  = Data;
          state_d = START;
          cnt_d   = '0;
          bit_d   = 3'd0;
        end
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = 3'd0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        bit_d   = 3'd0;
      end
    endcase
  end

  // Output logic: TX and FGO are registered from the state being entered.
  always_comb begin
    tx_d  = 1'b1;
    fgo_d = (state_d == IDLE);
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = outr_d[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  assign Q    = outr_q;
  assign FGO  = fgo_q;
  assign TX   = tx_q;
  assign BUSY = (state_q != IDLE);

endmodule

// File: tb/tb_output_tx.sv
// Bench for output_tx with CLKS_PER_BIT=4. Stimulus pushes the byte each
// accepted frame must carry; a negedge monitor reassembles frames from TX and
// checks them, plus FGO/BUSY/Q behaviour over the 40-cycle frame.
module tb_output_tx;

  localparam int N = 4;

  logic       clk;
  logic       clr;
  logic [7:0] data;
  logic       ld;
  logic [7:0] q;
  logic       fgo;
  logic       tx;
  logic       busy;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  output_tx #(.CLKS_PER_BIT(N)) dut (
    .CLK  (clk),
    .CLR  (clr),
    .Data (data),
    .LD   (ld),
    .Q    (q),
    .FGO  (fgo),
    .TX   (tx),
    .BUSY (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%02h required=0x%02h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%02h", name, act);
    end
  endtask

  // Monitor: tracks one frame from the first BUSY cycle, samples TX mid-bit.
  bit         mon_active = 0;
  int         mon_cyc = 0;
  logic [9:0] mon_bits;
  logic [7:0] mon_q0;
  bit         mon_bad_flags;
  bit         mon_bad_q;
  logic [7:0] mon_exp;

  always @(negedge clk) begin
    if (clr) begin
      mon_active = 0;
    end else begin
      if (!mon_active && busy) begin
        mon_active    = 1;
        mon_cyc       = 0;
        mon_q0        = q;
        mon_bad_flags = 0;
        mon_bad_q     = 0;
        mon_bits      = '0;
      end
      if (mon_active) begin
        if (mon_cyc < 10 * N) begin
          if (mon_cyc % N == 1) mon_bits[mon_cyc / N] = tx;
          if (fgo !== 1'b0 || busy !== 1'b1) mon_bad_flags = 1;
          if (q !== mon_q0) mon_bad_q = 1;
          mon_cyc++;
        end else begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL frame_unexpected actual=0x%02h required=none", mon_bits[8:1]);
          end else begin
            mon_exp = exp_q.pop_front();
            check("frame_start_bit", {7'd0, mon_bits[0]}, 8'h00);
            check("frame_data", mon_bits[8:1], mon_exp);
            check("frame_stop_bit", {7'd0, mon_bits[9]}, 8'h01);
            check("frame_q_held", mon_q0, mon_exp);
            check("frame_q_stable", {7'd0, mon_bad_q}, 8'h00);
            check("frame_fgo_busy_40", {7'd0, mon_bad_flags}, 8'h00);
            check("frame_end_fgo", {7'd0, fgo}, 8'h01);
            check("frame_end_busy", {7'd0, busy}, 8'h00);
          end
          mon_active = 0;
        end
      end
    end
  end

  task automatic send(input logic [7:0] d);
    @(posedge clk); #1;
    ld   = 1'b1;
    data = d;
    @(posedge clk); #1;
    ld   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(fgo === 1'b1 && busy === 1'b0) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL wait_idle_timeout actual=busy required=idle");
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    clr  = 1'b1;
    ld   = 1'b0;
    data = 8'h00;
    #23;
    check("reset_q", q, 8'h00);
    check("reset_fgo", {7'd0, fgo}, 8'h01);
    check("reset_tx", {7'd0, tx}, 8'h01);
    check("reset_busy", {7'd0, busy}, 8'h00);
    @(posedge clk); #1;
    clr = 1'b0;

    // Basic frame 0x41.
    exp_q.push_back(8'h41);
    send(8'h41);
    check("ld_clears_fgo", {7'd0, fgo}, 8'h00);
    check("ld_tx_start", {7'd0, tx}, 8'h00);
    wait_idle();

    // LD during a frame is ignored.
    exp_q.push_back(8'h41);
    send(8'h41);
    repeat (8) @(posedge clk);
    #1;
    ld   = 1'b1;
    data = 8'hFF;
    @(posedge clk); #1;
    ld = 1'b0;
    check("ignored_ld_q", q, 8'h41);
    wait_idle();
    check("after_ignored_q", q, 8'h41);

    // Back-to-back: LD on the first FGO=1 cycle.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hA5);
    send(8'h00);
    for (int i = 0; i < 60 && fgo !== 1'b1; i++) begin
      @(posedge clk); #1;
    end
    ld   = 1'b1;
    data = 8'hA5;
    @(posedge clk); #1;
    ld = 1'b0;
    check("b2b_accepted_busy", {7'd0, busy}, 8'h01);
    check("b2b_q", q, 8'hA5);
    wait_idle();

    // Asynchronous clear mid-frame, LD held during clear is ignored.
    send(8'h3C);
    repeat (16) @(posedge clk);
    #2;
    clr = 1'b1;
    #1;
    check("clr_tx", {7'd0, tx}, 8'h01);
    check("clr_fgo", {7'd0, fgo}, 8'h01);
    check("clr_q", q, 8'h00);
    check("clr_busy", {7'd0, busy}, 8'h00);
    ld   = 1'b1;
    data = 8'h77;
    repeat (2) @(posedge clk);
    #1;
    check("clr_ld_ignored_q", q, 8'h00);
    ld  = 1'b0;
    clr = 1'b0;
    exp_q.push_back(8'h55);
    send(8'h55);
    wait_idle();

    // Data changes after the accepted LD do not affect the frame.
    exp_q.push_back(8'h41);
    send(8'h41);
    data = 8'h00;
    wait_idle();

    check("scoreboard_empty", 8'(exp_q.size()), 8'h00);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/output_tx.md
OUTPUT_TX -- requirements
Module: output_tx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 16, clock cycles per serial bit period; legal range 2..65535.
REQ-002 Port: CLK  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: CLR  input  1  reset; asynchronous, active-high.
REQ-004 Port: Data  input  8  byte to transmit, driven from AC[7:0].
REQ-005 Port: LD  input  1  OUT-instruction strobe; loads OUTR and starts a frame.
REQ-006 Port: Q  output  8  current OUTR contents.
REQ-007 Port: FGO  output  1  output flag; 1 = ready for a new byte, 0 = frame in progress.
REQ-008 Port: TX  output  1  serial line, idle high.
REQ-009 Port: BUSY  output  1  1 whenever the state is not IDLE.

Function
REQ-010 States SHALL be IDLE, START, DATA, STOP; encoding is free.
REQ-011 In IDLE, TX SHALL be 1, FGO SHALL be 1, and BUSY SHALL be 0.
REQ-012 A rising edge with LD=1 in IDLE SHALL load OUTR<=Data, clear FGO, enter START, and zero the baud counter and bit index.
REQ-013 LD=1 outside IDLE SHALL be ignored; OUTR, the state and the counters SHALL be unchanged, with no queuing.
REQ-014 TX SHALL be registered: 0 in START, OUTR[bit index] in DATA, and 1 in STOP and IDLE.
REQ-015 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0; each wrap ends the current bit period.
REQ-016 At the end of START, the block SHALL enter DATA with bit index 0.
REQ-017 In DATA, each bit-period end SHALL increment the bit index; after index 7 the block SHALL enter STOP.
REQ-018 Bits SHALL be sent LSB first (OUTR[0] first).
REQ-019 At the end of STOP, the block SHALL return to IDLE and set FGO=1.
REQ-020 From the LD edge to FGO=1 SHALL be exactly 10*CLKS_PER_BIT cycles.
REQ-021 LD may be asserted on the same edge FGO returns to 1 only if the state is already IDLE; the first IDLE cycle SHALL accept LD.
REQ-022 Q SHALL hold OUTR for the whole frame and after it, until the next accepted LD.
REQ-023 Data SHALL be sampled only on the accepted LD edge; later Data changes SHALL NOT affect the frame.
REQ-024 Counter widths SHALL cover CLKS_PER_BIT-1 without overflow; the bit index SHALL be 3 bits.

Reset
REQ-025 When CLR=1, the block SHALL immediately enter IDLE with OUTR=8'h00, FGO=1, TX=1, BUSY=0, and counters at 0, regardless of CLK.
REQ-026 CLR asserted mid-frame SHALL abort the frame; TX SHALL go to 1 with no stop-bit completion.
REQ-027 LD asserted while CLR=1 SHALL be ignored.
REQ-028 Normal operation SHALL resume on the first rising CLK edge after CLR deasserts.

Verification (CLKS_PER_BIT=4)
REQ-029 Apply CLR pulse -> Q=0x00, FGO=1, TX=1, BUSY=0.
REQ-030 LD=1 with Data=0x41 for one cycle -> TX sequence 0,1,0,0,0,0,0,1,0,1, each held 4 cycles; FGO=0 for 40 cycles, then 1; Q=0x41 throughout.
REQ-031 Load 0x41, then pulse LD with Data=0xFF at cycle 10 -> the frame stays 0x41 and Q stays 0x41.
REQ-032 Load 0x00, then pulse LD with Data=0xA5 on the first cycle FGO=1 -> a second frame 0,1,0,1,0,0,1,0,1,1 follows the first with no gap beyond the stop bit.
REQ-033 Load 0x3C, then assert CLR at cycle 17 -> TX=1, FGO=1, Q=0x00 asynchronously; the next LD with Data=0x55 transmits a clean frame.
REQ-034 Change Data from 0x41 to 0x00 one cycle after the accepted LD -> TX still carries 0x41.
